// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch FSM encodings
package cpu_pkg;

    localparam int CPU_ADDR_W  = 19;
    localparam int CPU_INSTR_W = 19;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = '0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE = 2'd0;
    localparam fetch_state_t FETCH_REQ  = 2'd1;
    localparam fetch_state_t FETCH_HOLD = 2'd2;

endpackage

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and single-outstanding instruction fetch stage
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next,
    output logic [INSTR_W-1:0] out_instr
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic              kill;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_d;
    logic              kill_d;
    logic              valid_d;
    logic              req_d;
    logic              load_word;

    assign pc_inc = pc + PC_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH_IDLE: next_state = FETCH_REQ;
            FETCH_REQ: begin
                if (!redirect_valid && imem_ack && !kill) begin
                    next_state = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid || out_ready) begin
                    next_state = FETCH_REQ;
                end
            end
            default: next_state = FETCH_IDLE;
        endcase
    end

    // The fetch address only moves when no request is outstanding, so a
    // redirect mid-request parks the target in pc and marks the fetch killed.
    always_comb begin
        pc_d      = pc;
        kill_d    = kill;
        addr_d    = imem_addr;
        valid_d   = out_valid;
        load_word = 1'b0;
        case (state)
            FETCH_IDLE: begin
                pc_d   = redirect_valid ? redirect_addr : pc;
                addr_d = pc_d;
            end
            FETCH_REQ: begin
                if (redirect_valid) begin
                    pc_d   = redirect_addr;
                    kill_d = !imem_ack;
                    if (imem_ack) begin
                        addr_d = redirect_addr;
                    end
                end else if (imem_ack) begin
                    if (kill) begin
                        kill_d = 1'b0;
                        addr_d = pc;
                    end else begin
                        load_word = 1'b1;
                        pc_d      = pc_inc;
                        valid_d   = 1'b1;
                    end
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    addr_d  = redirect_addr;
                    valid_d = 1'b0;
                end else if (out_ready) begin
                    addr_d  = pc;
                    valid_d = 1'b0;
                end
            end
            default: begin
                pc_d    = RESET_PC;
                kill_d  = 1'b0;
                addr_d  = '0;
                valid_d = 1'b0;
            end
        endcase
        req_d = (next_state == FETCH_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            kill        <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_pc_next <= '0;
            out_instr   <= '0;
        end else begin
            pc        <= pc_d;
            kill      <= kill_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            out_valid <= valid_d;
            if (load_word) begin
                out_pc      <= pc;
                out_pc_next <= pc_inc;
                out_instr   <= imem_rdata;
            end
        end
    end

endmodule
